tdm_demux_1x8: RTL and testbench

Time-division 1-to-8 demultiplexer, the receive-side counterpart of the 8-to-1 selector path. It accepts a serial stream of W-bit beats with a frame-sync marker and routes each beat to lane 0..7 using an internal 3-bit slot counter. When all eight lanes of a frame are collected, it publishes them as one registered 8-lane word with a single-cycle frame strobe. It sits at the far end of a TDM link, recovering the eight parallel channels that the upstream mux serialised.

---
 rtl/tdm_pkg.sv | 21 ++
 rtl/dmux_1x8.sv | 27 ++
 rtl/tdm_demux_1x8.sv | 140 ++++++++++++++
 tb/tb_tdm_demux_1x8.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tdm_pkg
//  Description : Shared definitions for the TDM framer / deframer pair.
//                Holds the slot count, the slot counter width and the
//                frame-alignment state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package tdm_pkg;

    localparam int NUM_SLOTS = 8;
    localparam int SLOT_W    = 3;

    // Frame alignment: HUNT waits for a sync beat, LOCK tracks slots.
    typedef enum logic [0:0] {
        HUNT = 1'b0,
        LOCK = 1'b1
    } tdm_state_e;

endpackage
`default_nettype wire

// File: rtl/dmux_1x8.sv
`default_nettype none
// ============================================================================
//  Module      : dmux_1x8
//  Description : Combinational 1-to-8 decoder. Converts a slot index into a
//                one-hot lane write-enable, all zeros when not enabled.
//  Ports       : slot_i - slot index (SLOT_W bits)
//                en_i   - decoder enable
//                we_o   - one-hot write-enable (NUM_SLOTS bits)
//  Revision    : 1.0 - initial release
// ============================================================================
module dmux_1x8
    import tdm_pkg::*;
(
    input  logic [SLOT_W-1:0]    slot_i,
    input  logic                 en_i,
    output logic [NUM_SLOTS-1:0] we_o
);

    always_comb begin
        we_o = '0;
        if (en_i) begin
            we_o[slot_i] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tdm_demux_1x8.sv
`default_nettype none
// ============================================================================
//  Module      : tdm_demux_1x8
//  Description : Time-division 1-to-8 demultiplexer. Routes serial W-bit
//                beats into eight shadow lanes using a 3-bit slot counter
//                aligned by a frame-sync marker, and publishes each complete
//                frame as one registered 8-lane word with a one-cycle strobe.
//  Ports       : clk         - rising-edge clock
//                rst_n       - synchronous reset, active low
//                D           - serial beat data (W bits)
//                d_valid     - beat qualifier
//                sync        - marks the current beat as slot 0
//                Y           - recovered frame, lane k at Y[k*W +: W]
//                frame_valid - one-cycle pulse when Y takes a new frame
//                locked      - high while frame-aligned
//                sync_err    - one-cycle pulse on a misplaced sync
//  Config      : TDM_DEMUX_SYNC_CHK_EN - when defined, a sync seen at a
//                non-zero slot discards the partial frame, restarts at lane 0
//                and pulses sync_err. When undefined, sync only matters in
//                HUNT and sync_err is held at 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module tdm_demux_1x8
    import tdm_pkg::*;
#(
    parameter int W = 1
)
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [W-1:0]         D,
    input  logic                 d_valid,
    input  logic                 sync,
    output logic [NUM_SLOTS*W-1:0] Y,
    output logic                 frame_valid,
    output logic                 locked,
    output logic                 sync_err
);

    tdm_state_e                state_q;
    logic [SLOT_W-1:0]         slot_q;
    logic [NUM_SLOTS*W-1:0]    shadow_q;
    logic [NUM_SLOTS*W-1:0]    y_q;
    logic                      frame_valid_q;
    logic                      locked_q;
    logic                      sync_err_q;

    logic                      w_resync;
    logic [SLOT_W-1:0]         w_wr_slot;
    logic                      w_wr_en;
    logic [NUM_SLOTS-1:0]      w_we;
    logic                      w_frame_done;
    logic [NUM_SLOTS*W-1:0]    y_d;

`ifdef TDM_DEMUX_SYNC_CHK_EN
    // A sync away from slot 0 while locked restarts the frame at lane 0.
    assign w_resync = (state_q == LOCK) && sync && (slot_q != '0);
`else
    assign w_resync = 1'b0;
`endif

    // In HUNT the only beat ever written is the sync beat, which is lane 0.
    assign w_wr_slot = ((state_q == HUNT) || w_resync) ? '0 : slot_q;
    assign w_wr_en   = d_valid && ((state_q == LOCK) || sync);

    // A resync forces the write slot to 0, so it can never complete a frame
    // in the same beat; sync_err and frame_valid are mutually exclusive.
    assign w_frame_done = d_valid && (state_q == LOCK) &&
                          (w_wr_slot == SLOT_W'(NUM_SLOTS - 1));

    // The last lane comes straight from the input so the frame publishes on
    // the edge that samples the 8th beat.
    assign y_d = {D, shadow_q[(NUM_SLOTS-1)*W-1:0]};

    dmux_1x8 u_dmux (
        .slot_i (w_wr_slot),
        .en_i   (w_wr_en),
        .we_o   (w_we)
    );

    // Shadow lanes are never cleared between frames; every lane is
    // rewritten before the next publish.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_q <= '0;
        end else begin
            for (int k = 0; k < NUM_SLOTS; k++) begin
                if (w_we[k]) begin
                    shadow_q[k*W +: W] <= D;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= HUNT;
            slot_q        <= '0;
            y_q           <= '0;
            frame_valid_q <= 1'b0;
            locked_q      <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
            if (d_valid) begin
                case (state_q)
                    HUNT: begin
                        if (sync) begin
                            state_q  <= LOCK;
                            slot_q   <= SLOT_W'(1);
                            locked_q <= 1'b1;
                        end
                    end
                    LOCK: begin
                        // 7 -> 0 wrap is plain 3-bit overflow.
                        slot_q     <= w_wr_slot + SLOT_W'(1);
                        sync_err_q <= w_resync;
                        if (w_frame_done) begin
                            y_q           <= y_d;
                            frame_valid_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q  <= HUNT;
                        slot_q   <= '0;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign Y           = y_q;
    assign frame_valid = frame_valid_q;
    assign locked      = locked_q;
    assign sync_err    = sync_err_q;

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux_1x8.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tdm_demux_1x8
//  Description : Self-checking bench for tdm_demux_1x8 with W=1. A table of
//                per-cycle vectors covers HUNT discard and back-to-back
//                frames; hand-written sequences cover gapped valid,
//                misplaced sync (both builds of TDM_DEMUX_SYNC_CHK_EN) and
//                mid-frame reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tdm_demux_1x8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [0:0] D;
    logic       d_valid;
    logic       sync;
    logic [7:0] Y;
    logic       frame_valid;
    logic       locked;
    logic       sync_err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       dv;
        logic       s;
        logic       d;
        logic       fv;
        logic [7:0] y;
        logic       lk;
    } vec_t;

    vec_t tbl[$];

    tdm_demux_1x8 #(.W(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .D           (D),
        .d_valid     (d_valid),
        .sync        (sync),
        .Y           (Y),
        .frame_valid (frame_valid),
        .locked      (locked),
        .sync_err    (sync_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic dv, input logic s, input logic d,
                       input logic fv, input logic [7:0] y, input logic lk);
        vec_t v;
        v.dv = dv; v.s = s; v.d = d; v.fv = fv; v.y = y; v.lk = lk;
        tbl.push_back(v);
    endtask

    // Drive one cycle, then sample 1 time unit after the rising edge.
    task automatic cyc(input logic dv, input logic s, input logic d);
        d_valid = dv;
        sync    = s;
        D       = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] pat;
        logic [7:0] y_prev;
        int         fv_cnt;
        int         first_fv;
        int         second_fv;
        logic       exp_fv;
        logic       exp_se;

        rst_n = 1'b0; d_valid = 1'b0; sync = 1'b0; D = 1'b0;

        // ---------------- reset state ----------------
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("reset_Y", Y, 8'h00);
        chk("reset_fv", {7'd0, frame_valid}, 8'd0);
        chk("reset_locked", {7'd0, locked}, 8'd0);
        chk("reset_sync_err", {7'd0, sync_err}, 8'd0);
        rst_n = 1'b1;

        // ---------------- vector table ----------------
        // HUNT discard: three beats without sync.
        add(1, 0, 1, 0, 8'h00, 0);
        add(1, 0, 1, 0, 8'h00, 0);
        add(1, 0, 0, 0, 8'h00, 0);
        // Frame 8'h4D, lane0 first: 1,0,1,1,0,0,1,0.
        add(1, 1, 1, 0, 8'h00, 1);
        add(1, 0, 0, 0, 8'h00, 1);
        add(1, 0, 1, 0, 8'h00, 1);
        add(1, 0, 1, 0, 8'h00, 1);
        add(1, 0, 0, 0, 8'h00, 1);
        add(1, 0, 0, 0, 8'h00, 1);
        add(1, 0, 1, 0, 8'h00, 1);
        add(1, 0, 0, 1, 8'h4D, 1);
        // Back-to-back frame 8'hA5: 1,0,1,0,0,1,0,1.
        add(1, 1, 1, 0, 8'h4D, 1);
        add(1, 0, 0, 0, 8'h4D, 1);
        add(1, 0, 1, 0, 8'h4D, 1);
        add(1, 0, 0, 0, 8'h4D, 1);
        add(1, 0, 0, 0, 8'h4D, 1);
        add(1, 0, 1, 0, 8'h4D, 1);
        add(1, 0, 0, 0, 8'h4D, 1);
        add(1, 0, 1, 1, 8'hA5, 1);
        // Idle, including a sync that is not qualified by d_valid.
        add(0, 0, 1, 0, 8'hA5, 1);
        add(0, 1, 1, 0, 8'hA5, 1);

        first_fv  = -1;
        second_fv = -1;
        foreach (tbl[i]) begin
            cyc(tbl[i].dv, tbl[i].s, tbl[i].d);
            chk($sformatf("tbl%0d_fv", i), {7'd0, frame_valid}, {7'd0, tbl[i].fv});
            chk($sformatf("tbl%0d_Y", i), Y, tbl[i].y);
            chk($sformatf("tbl%0d_locked", i), {7'd0, locked}, {7'd0, tbl[i].lk});
            if (frame_valid === 1'b1) begin
                if (first_fv < 0) first_fv = i;
                else second_fv = i;
            end
        end
        chk("b2b_spacing", 8'(second_fv - first_fv), 8'd8);

        // ---------------- gapped valid ----------------
        pat    = 8'h4D;
        fv_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, (i == 0), pat[i]);
            if (frame_valid === 1'b1) fv_cnt++;
            chk($sformatf("gap_beat%0d_fv", i), {7'd0, frame_valid}, {7'd0, (i == 7)});
            y_prev = (i == 7) ? 8'h4D : 8'hA5;
            chk($sformatf("gap_beat%0d_Y", i), Y, y_prev);
            for (int g = 0; g < 2; g++) begin
                cyc(1'b0, 1'b0, ~pat[i]);
                if (frame_valid === 1'b1) fv_cnt++;
                chk($sformatf("gap_idle%0d_%0d_Y", i, g), Y, y_prev);
            end
        end
        chk("gap_fv_count", 8'(fv_cnt), 8'd1);

        // ---------------- misplaced sync ----------------
        // Beats 0..4 carry zeros (sync on beat 0); beats 5..12 carry ones
        // with sync on beat 5, i.e. at slot 5.
        fv_cnt = 0;
        for (int k = 0; k < 13; k++) begin
            cyc(1'b1, (k == 0) || (k == 5), (k >= 5));
`ifdef TDM_DEMUX_SYNC_CHK_EN
            exp_fv = (k == 12);
            exp_se = (k == 5);
`else
            exp_fv = (k == 7);
            exp_se = 1'b0;
`endif
            if (frame_valid === 1'b1) fv_cnt++;
            chk($sformatf("mis%0d_fv", k), {7'd0, frame_valid}, {7'd0, exp_fv});
            chk($sformatf("mis%0d_sync_err", k), {7'd0, sync_err}, {7'd0, exp_se});
        end
`ifdef TDM_DEMUX_SYNC_CHK_EN
        chk("mis_Y", Y, 8'hFF);
`else
        chk("mis_Y", Y, 8'hE0);
`endif
        chk("mis_fv_count", 8'(fv_cnt), 8'd1);

        // ---------------- mid-frame reset ----------------
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1);
        rst_n = 1'b0;
        cyc(1'b1, 1'b0, 1'b1);
        chk("mrst_Y", Y, 8'h00);
        chk("mrst_locked", {7'd0, locked}, 8'd0);
        chk("mrst_fv", {7'd0, frame_valid}, 8'd0);
        rst_n = 1'b1;
        // A non-sync beat must be dropped after the reset.
        cyc(1'b1, 1'b0, 1'b1);
        chk("mrst_hunt_locked", {7'd0, locked}, 8'd0);
        pat = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, (i == 0), pat[i]);
            chk($sformatf("mrst_beat%0d_fv", i), {7'd0, frame_valid}, {7'd0, (i == 7)});
        end
        chk("mrst_Y_3C", Y, 8'h3C);
        chk("mrst_locked_after", {7'd0, locked}, 8'd1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("mrst_fv_one_cycle", {7'd0, frame_valid}, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
